// File: rtl/alu_op_sequencer.sv
// Registered request/response front end for a 32-bit combinational ALU with a chained carry flag.
// Optional feature: define ALU_SEQ_STICKY_OVF_EN to add the ovf_sticky output.
module alu_op_sequencer #(
   parameter int WIDTH         = 32,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   input  logic [3:0]       req_sel,
   input  logic             req_cin,
   input  logic             req_chain,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [3:0]       alu_sel,
   output logic             alu_cin,
   input  logic [WIDTH-1:0] alu_y,
   input  logic             alu_cout,
   input  logic             alu_neg,
   input  logic             alu_zero,
   input  logic             alu_ovf,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_y,
   output logic [3:0]       rsp_flags,
   output logic             busy
`ifdef ALU_SEQ_STICKY_OVF_EN
   ,
   output logic             ovf_sticky
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DRIVE  = 2'd1,
      ST_SETTLE = 2'd2,
      ST_RESP   = 2'd3
   } state_t;

   state_t           state_r, state_s;
   logic [3:0]       cnt_r, cnt_s;
   logic [WIDTH-1:0] alu_a_r, alu_a_s, alu_b_r, alu_b_s;
   logic [3:0]       alu_sel_r, alu_sel_s;
   logic             alu_cin_r, alu_cin_s;
   logic             rsp_valid_r, rsp_valid_s;
   logic [WIDTH-1:0] rsp_y_r, rsp_y_s;
   logic [3:0]       rsp_flags_r, rsp_flags_s;
   logic             carry_r, carry_s;
   logic             req_ready_r, req_ready_s;
   logic             busy_r, busy_s;
   logic             accept_s, capture_s;

   assign accept_s  = (state_r == ST_IDLE) && req_valid;
   assign capture_s = (state_r == ST_SETTLE) && (cnt_r == 4'd0);

   // Next-state and next-output logic for the sequencer FSM.
   always_comb begin
      state_s     = state_r;
      cnt_s       = cnt_r;
      alu_a_s     = alu_a_r;
      alu_b_s     = alu_b_r;
      alu_sel_s   = alu_sel_r;
      alu_cin_s   = alu_cin_r;
      rsp_valid_s = rsp_valid_r;
      rsp_y_s     = rsp_y_r;
      rsp_flags_s = rsp_flags_r;
      carry_s     = carry_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               alu_a_s   = req_a;
               alu_b_s   = req_b;
               alu_sel_s = req_sel;
               alu_cin_s = req_chain ? carry_r : req_cin;
               state_s   = ST_DRIVE;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_DRIVE: begin
            cnt_s   = 4'(SETTLE_CYCLES - 1);
            state_s = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (capture_s) begin
               rsp_y_s     = alu_y;
               rsp_flags_s = {alu_cout, alu_neg, alu_zero, alu_ovf};
               carry_s     = alu_cout;
               rsp_valid_s = 1'b1;
               state_s     = ST_RESP;
            end else begin
               cnt_s = cnt_r - 4'd1;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               rsp_valid_s = 1'b0;
               state_s     = ST_IDLE;
            end else begin
               state_s = ST_RESP;
            end
         end
         default: begin
            state_s     = ST_IDLE;
            rsp_valid_s = 1'b0;
         end
      endcase
      // Ready/busy are registered copies of the next state, so no comb path from rsp_ready.
      req_ready_s = (state_s == ST_IDLE);
      busy_s      = (state_s != ST_IDLE);
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         cnt_r       <= 4'd0;
         alu_a_r     <= '0;
         alu_b_r     <= '0;
         alu_sel_r   <= 4'd0;
         alu_cin_r   <= 1'b0;
         rsp_valid_r <= 1'b0;
         rsp_y_r     <= '0;
         rsp_flags_r <= 4'd0;
         carry_r     <= 1'b0;
         req_ready_r <= 1'b1;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_s;
         cnt_r       <= cnt_s;
         alu_a_r     <= alu_a_s;
         alu_b_r     <= alu_b_s;
         alu_sel_r   <= alu_sel_s;
         alu_cin_r   <= alu_cin_s;
         rsp_valid_r <= rsp_valid_s;
         rsp_y_r     <= rsp_y_s;
         rsp_flags_r <= rsp_flags_s;
         carry_r     <= carry_s;
         req_ready_r <= req_ready_s;
         busy_r      <= busy_s;
      end
   end

   assign req_ready = req_ready_r;
   assign alu_a     = alu_a_r;
   assign alu_b     = alu_b_r;
   assign alu_sel   = alu_sel_r;
   assign alu_cin   = alu_cin_r;
   assign rsp_valid = rsp_valid_r;
   assign rsp_y     = rsp_y_r;
   assign rsp_flags = rsp_flags_r;
   assign busy      = busy_r;

`ifdef ALU_SEQ_STICKY_OVF_EN
   logic sticky_r, sticky_s;

   // Sticky overflow: cleared by an unchained sel=1111 request, otherwise accumulates on capture.
   always_comb begin
      sticky_s = sticky_r;
      if (accept_s && !req_chain && (req_sel == 4'b1111)) begin
         sticky_s = 1'b0;
      end else if (capture_s) begin
         sticky_s = sticky_r | alu_ovf;
      end else begin
         sticky_s = sticky_r;
      end
   end

   // Sticky overflow register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sticky_r <= 1'b0;
      end else begin
         sticky_r <= sticky_s;
      end
   end

   assign ovf_sticky = sticky_r;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: dut 0 uses SETTLE_CYCLES=1, dut 1 uses SETTLE_CYCLES=4.
module tb_alu_op_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid [2];
   logic        req_ready [2];
   logic [31:0] req_a [2];
   logic [31:0] req_b [2];
   logic [3:0]  req_sel [2];
   logic        req_cin [2];
   logic        req_chain [2];
   logic [31:0] alu_a [2];
   logic [31:0] alu_b [2];
   logic [3:0]  alu_sel [2];
   logic        alu_cin [2];
   logic [31:0] alu_y [2];
   logic        alu_cout [2];
   logic        alu_neg [2];
   logic        alu_zero [2];
   logic        alu_ovf [2];
   logic        rsp_valid [2];
   logic        rsp_ready [2];
   logic [31:0] rsp_y [2];
   logic [3:0]  rsp_flags [2];
   logic        busy [2];
   logic        sticky [2];
   logic [35:0] m0, m1;
   logic [35:0] q0 [$];
   logic [35:0] q1 [$];
   int          total = 0;
   int          bad = 0;

   always #5 clk = ~clk;

   alu_op_sequencer #(.WIDTH(32), .SETTLE_CYCLES(1)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
      .req_a(req_a[0]), .req_b(req_b[0]), .req_sel(req_sel[0]), .req_cin(req_cin[0]),
      .req_chain(req_chain[0]), .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_sel(alu_sel[0]),
      .alu_cin(alu_cin[0]), .alu_y(alu_y[0]), .alu_cout(alu_cout[0]), .alu_neg(alu_neg[0]),
      .alu_zero(alu_zero[0]), .alu_ovf(alu_ovf[0]), .rsp_valid(rsp_valid[0]),
      .rsp_ready(rsp_ready[0]), .rsp_y(rsp_y[0]), .rsp_flags(rsp_flags[0]), .busy(busy[0])
`ifdef ALU_SEQ_STICKY_OVF_EN
      , .ovf_sticky(sticky[0])
`endif
   );

   alu_op_sequencer #(.WIDTH(32), .SETTLE_CYCLES(4)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
      .req_a(req_a[1]), .req_b(req_b[1]), .req_sel(req_sel[1]), .req_cin(req_cin[1]),
      .req_chain(req_chain[1]), .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_sel(alu_sel[1]),
      .alu_cin(alu_cin[1]), .alu_y(alu_y[1]), .alu_cout(alu_cout[1]), .alu_neg(alu_neg[1]),
      .alu_zero(alu_zero[1]), .alu_ovf(alu_ovf[1]), .rsp_valid(rsp_valid[1]),
      .rsp_ready(rsp_ready[1]), .rsp_y(rsp_y[1]), .rsp_flags(rsp_flags[1]), .busy(busy[1])
`ifdef ALU_SEQ_STICKY_OVF_EN
      , .ovf_sticky(sticky[1])
`endif
   );

   // Reference ALU; result packed as {cout, neg, zero, ovf, y}.
   function automatic logic [35:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] sel, input logic cin);
      logic [31:0] y;
      logic        c, v;
      c = 1'b0;
      v = 1'b0;
      case (sel)
         4'b0000: y = a & b;
         4'b0001: y = a | b;
         4'b0010: y = ~a;
         4'b0011: y = ~(a | b);
         4'b0100: y = a ^ b;
         4'b0101: y = ~(a & b);
         4'b0110: begin
            {c, y} = {1'b0, a} + {1'b0, b} + {32'd0, cin};
            v = (a[31] == b[31]) && (y[31] != a[31]);
         end
         4'b0111: begin
            {c, y} = {1'b0, a} + {1'b0, ~b} + 33'd1;
            v = (a[31] != b[31]) && (y[31] != a[31]);
         end
         default: y = 32'd0;
      endcase
      return {c, y[31], (y == 32'd0), v, y};
   endfunction

   always_comb m0 = alu_f(alu_a[0], alu_b[0], alu_sel[0], alu_cin[0]);
   always_comb m1 = alu_f(alu_a[1], alu_b[1], alu_sel[1], alu_cin[1]);
   assign {alu_cout[0], alu_neg[0], alu_zero[0], alu_ovf[0], alu_y[0]} = m0;
   assign {alu_cout[1], alu_neg[1], alu_zero[1], alu_ovf[1], alu_y[1]} = m1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor for dut 0: pop expected response at every handshake.
   always @(negedge clk) begin
      if (rsp_valid[0] === 1'b1 && rsp_ready[0] === 1'b1) begin
         if (q0.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rsp0_unexpected: got y=%0h with empty scoreboard", rsp_y[0]);
         end else begin
            logic [35:0] e;
            e = q0.pop_front();
            chk("rsp0_y", 64'(rsp_y[0]), 64'(e[31:0]));
            chk("rsp0_flags", 64'(rsp_flags[0]), 64'(e[35:32]));
         end
      end
   end

   // Monitor for dut 1.
   always @(negedge clk) begin
      if (rsp_valid[1] === 1'b1 && rsp_ready[1] === 1'b1) begin
         if (q1.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rsp1_unexpected: got y=%0h with empty scoreboard", rsp_y[1]);
         end else begin
            logic [35:0] e;
            e = q1.pop_front();
            chk("rsp1_y", 64'(rsp_y[1]), 64'(e[31:0]));
            chk("rsp1_flags", 64'(rsp_flags[1]), 64'(e[35:32]));
         end
      end
   end

   // Present a request and wait until it is accepted (edge at which it was taken has passed).
   task automatic issue(input int d, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] sel, input logic cin, input logic chain);
      int n;
      @(negedge clk);
      req_a[d] = a;
      req_b[d] = b;
      req_sel[d] = sel;
      req_cin[d] = cin;
      req_chain[d] = chain;
      req_valid[d] = 1'b1;
      n = 0;
      while (req_ready[d] !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         total++;
         bad++;
         $display("FAIL req_ready_timeout: dut %0d never ready", d);
      end
      @(posedge clk);
      #1 req_valid[d] = 1'b0;
   endtask

   // Full op: scoreboard push, issue, latency check, wait for idle.
   task automatic do_op(input int d, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] sel, input logic cin, input logic chain,
                        input logic [31:0] ey, input logic [3:0] ef, input int elat);
      int lat;
      if (d == 0) q0.push_back({ef, ey});
      else q1.push_back({ef, ey});
      issue(d, a, b, sel, cin, chain);
      lat = 1;
      while (rsp_valid[d] !== 1'b1 && lat < 60) begin
         @(posedge clk);
         #1 lat++;
      end
      chk($sformatf("latency_d%0d", d), 64'(lat), 64'(elat));
      lat = 0;
      while (busy[d] !== 1'b0 && lat < 60) begin
         @(negedge clk);
         lat++;
      end
      if (lat >= 60) begin
         total++;
         bad++;
         $display("FAIL idle_timeout: dut %0d stuck busy", d);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 2; i++) begin
         req_valid[i] = 1'b0;
         req_a[i] = 32'd0;
         req_b[i] = 32'd0;
         req_sel[i] = 4'd0;
         req_cin[i] = 1'b0;
         req_chain[i] = 1'b0;
         rsp_ready[i] = 1'b1;
      end
      repeat (3) @(negedge clk);
      chk("rst_rsp_valid", 64'(rsp_valid[0]), 64'd0);
      chk("rst_busy", 64'(busy[0]), 64'd0);
      chk("rst_alu_a", 64'(alu_a[0]), 64'd0);
      chk("rst_rsp_y", 64'(rsp_y[0]), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_req_ready", 64'(req_ready[0]), 64'd1);

      // Logic ops and two-word carry chain on the short-settle instance.
      do_op(0, 32'hF0F0F0F0, 32'hFF00FF00, 4'b0000, 1'b0, 1'b0, 32'hF000F000, 4'b0100, 3);
      do_op(0, 32'hFFFFFFFF, 32'h00000001, 4'b0110, 1'b0, 1'b0, 32'h00000000, 4'b1010, 3);
      do_op(0, 32'h00000000, 32'h00000000, 4'b0110, 1'b0, 1'b1, 32'h00000001, 4'b0000, 3);
      do_op(0, 32'hFFFF0000, 32'h0F0F0F0F, 4'b0100, 1'b0, 1'b0, 32'hF0F00F0F, 4'b0100, 3);
      do_op(0, 32'h00000005, 32'h00000007, 4'b0111, 1'b0, 1'b0, 32'hFFFFFFFE, 4'b0100, 3);

      // Backpressure: response held, request side blocked, extra request ignored.
      rsp_ready[0] = 1'b0;
      q0.push_back({4'b0000, 32'h12345678});
      issue(0, 32'h12340000, 32'h00005678, 4'b0001, 1'b0, 1'b0);
      for (int i = 0; i < 20 && rsp_valid[0] !== 1'b1; i++) @(negedge clk);
      @(negedge clk);
      req_a[0] = 32'hFFFFFFFF;
      req_b[0] = 32'hFFFFFFFF;
      req_sel[0] = 4'b0110;
      req_valid[0] = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_rsp_valid", 64'(rsp_valid[0]), 64'd1);
         chk("bp_rsp_y", 64'(rsp_y[0]), 64'h12345678);
         chk("bp_rsp_flags", 64'(rsp_flags[0]), 64'd0);
         chk("bp_req_ready", 64'(req_ready[0]), 64'd0);
      end
      @(posedge clk);
      #1;
      req_valid[0] = 1'b0;
      rsp_ready[0] = 1'b1;
      for (int i = 0; i < 20 && busy[0] !== 1'b0; i++) @(negedge clk);
      do_op(0, 32'h00000000, 32'h00000000, 4'b0111, 1'b0, 1'b0, 32'h00000000, 4'b1010, 3);

      // Long-settle instance: overflow add with six-cycle latency.
      do_op(1, 32'h7FFFFFFF, 32'h00000001, 4'b0110, 1'b0, 1'b0, 32'h80000000, 4'b0101, 6);
      do_op(1, 32'hFFFFFFFF, 32'h00000001, 4'b0110, 1'b0, 1'b0, 32'h00000000, 4'b1010, 6);

      // Reset in the middle of SETTLE drops the op and clears the carry flag.
      issue(1, 32'hDEADBEEF, 32'h00000001, 4'b0110, 1'b0, 1'b1);
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_rsp_valid", 64'(rsp_valid[1]), 64'd0);
      chk("midrst_alu_a", 64'(alu_a[1]), 64'd0);
      chk("midrst_busy", 64'(busy[1]), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      do_op(1, 32'h00000000, 32'h00000000, 4'b0110, 1'b1, 1'b1, 32'h00000000, 4'b0010, 6);

`ifdef ALU_SEQ_STICKY_OVF_EN
      do_op(0, 32'h7FFFFFFF, 32'h00000001, 4'b0110, 1'b0, 1'b0, 32'h80000000, 4'b0101, 3);
      do_op(0, 32'hF0F0F0F0, 32'hFF00FF00, 4'b0000, 1'b0, 1'b0, 32'hF000F000, 4'b0100, 3);
      chk("sticky_held", 64'(sticky[0]), 64'd1);
      do_op(0, 32'h00000000, 32'h00000000, 4'b1111, 1'b0, 1'b0, 32'h00000000, 4'b0010, 3);
      chk("sticky_cleared", 64'(sticky[0]), 64'd0);
`endif

      repeat (4) @(negedge clk);
      chk("scoreboard0_empty", 64'(q0.size()), 64'd0);
      chk("scoreboard1_empty", 64'(q1.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
